fft_peak_reader: RTL
====================

// Module: fft_peak_reader
// PURPOSE
//  Read-side consumer of one channel's FFT result RAM. Waits for fft_ready and sweeps
//  rd_addr over bins BIN_LO..BIN_HI. Computes |X|^2 = re^2+im^2 per bin, tracks the max bin,
//  presents the result on a valid/ack handshake, then pulses go to re-arm the FFT wrapper.
//  Sits between the per-channel FFT wrapper and the direction-estimation stage.
// PARAMETERS
//  DATA_W   14   width of each of re/im in ram_q (signed, two's complement)
//  ADDR_W   10   FFT RAM address width (1024 bins)
//  RD_LAT   1    cycles from rd_addr to valid ram_q; legal 1..3
//  BIN_LO   1    first bin scanned (DC skipped)
//  BIN_HI   511  last bin scanned, inclusive; BIN_LO <= BIN_HI < 2**ADDR_W
// PORTS
//  clk          in   1         clock
//  rst_n        in   1         synchronous, active-low reset
//  fft_ready    in   1         FFT RAM holds a complete frame (level)
//  ram_q        in   2*DATA_W  {re, im} read data, re in MSBs
//  rd_addr      out  ADDR_W    FFT RAM read address
//  go           out  1         1-cycle pulse: frame consumed, wrapper may restart
//  busy         out  1         high in any state other than IDLE
//  result_valid out  1         peak result valid; held until result_ack
//  result_ack   in   1         downstream accepts result (sampled while result_valid)
//  peak_bin     out  ADDR_W    bin index of maximum |X|^2
//  peak_mag     out  2*DATA_W  |X|^2 of peak bin, unsigned
//  peak_re      out  DATA_W    raw re of peak bin
//  peak_im      out  DATA_W    raw im of peak bin
// BEHAVIOUR
//  Reset (rst_n=0 at posedge), effective mid-frame as well:
//   state=IDLE; rd_addr=BIN_LO; go=0; result_valid=0; peak_*=0; pipeline valids cleared.
//  FSM: IDLE -> SCAN -> DRAIN -> HOLD -> RELEASE -> WAIT_LOW -> IDLE
//   IDLE: rd_addr=BIN_LO. fft_ready=1 -> SCAN. Clear running max (mag=0, bin=BIN_LO).
//   SCAN: one address issued per cycle. rd_addr increments each cycle.
//     Issuing BIN_HI -> DRAIN (rd_addr holds BIN_HI).
//   DRAIN: wait until the compare pipeline is empty (RD_LAT+2 cycles after last issue).
//     Then load peak_* from the running max, set result_valid=1 -> HOLD.
//   HOLD: peak_* and result_valid stable. result_ack=1 -> result_valid=0 next cycle -> RELEASE.
//   RELEASE: go=1 for exactly this cycle -> WAIT_LOW.
//   WAIT_LOW: stay until fft_ready=0 (the wrapper drops it after go), then -> IDLE.
//     This prevents re-reading a stale frame.
//  Datapath pipeline, an address tag travels alongside:
//   stage0 ram_q valid RAM_LAT after issue;
//   stage1 registers re*re and im*im, signed 2*DATA_W-1 bits each, zero-extended;
//   stage2 sum (2*DATA_W bits, no overflow: max 2*(2^26)=2^27) compared to running max.
//  Compare is strict (>): on ties the lowest bin wins. An all-zero frame reports bin BIN_LO, mag 0.
//  Latency: fft_ready rise -> result_valid = 1 + (BIN_HI-BIN_LO+1) + RD_LAT + 2 cycles.
//  fft_ready falling during SCAN/DRAIN: abort -> IDLE. No result_valid, no go.
//   Partial max is discarded.
//  result_ack while result_valid=0: ignored.
//  result_ack tied high: HOLD lasts exactly 1 cycle.
//  BIN_LO==BIN_HI: SCAN lasts 1 cycle; result is that bin.
// TESTING
//  1 Frame with bin 37 = {re=100, im=-50}, rest 0; RD_LAT=1
//    -> peak_bin=37, peak_mag=12500, peak_re=100, peak_im=-50;
//    result_valid 1+511+3=515 cycles after fft_ready.
//  2 Bins 20 and 300 both {re=-8192, im=-8192}
//    -> peak_bin=20, peak_mag=134217728 (tie, lowest bin, extreme values, no overflow).
//  3 Hold result_ack=0 for 50 cycles
//    -> result_valid and peak_* stable, go=0 throughout.
//    Then ack -> go high exactly 1 cycle, 2 cycles after ack.
//  4 After go, keep fft_ready high 10 more cycles
//    -> no new SCAN (rd_addr stays BIN_LO, busy=1 in WAIT_LOW).
//    fft_ready low then high -> new scan starts.
//  5 rst_n=0 at SCAN address 200 -> next cycle: IDLE, rd_addr=1, result_valid=0, go=0.
//    Next frame's result is unaffected by old data.
//  6 fft_ready drops at address 100 -> return to IDLE. No result_valid, no go.
//    Repeat tests 1-2 with RD_LAT=3 -> identical results, latency +2.

Source files
------------

// File: rtl/fft_peak_reader.sv
// Read-side consumer of one channel's FFT result RAM: sweeps bins BIN_LO..BIN_HI, finds
// the bin with the largest |X|^2 and hands it downstream before re-arming the FFT wrapper.
module fft_peak_reader #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1,
    parameter int BIN_LO = 1,
    parameter int BIN_HI = 511
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fft_ready,
    input  logic [2*DATA_W-1:0] ram_q,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic                go,
    output logic                busy,
    output logic                result_valid,
    input  logic                result_ack,
    output logic [ADDR_W-1:0]   peak_bin,
    output logic [2*DATA_W-1:0] peak_mag,
    output logic [DATA_W-1:0]   peak_re,
    output logic [DATA_W-1:0]   peak_im,
    output logic [2:0]          dbg_state
);

    localparam int MAG_W = 2 * DATA_W;
    localparam logic [ADDR_W-1:0] ADDR_LO    = ADDR_W'(BIN_LO);
    localparam logic [ADDR_W-1:0] ADDR_HI    = ADDR_W'(BIN_HI);
    localparam logic [2:0]        DRAIN_LAST = 3'(RD_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SCAN     = 3'd1,
        S_DRAIN    = 3'd2,
        S_HOLD     = 3'd3,
        S_RELEASE  = 3'd4,
        S_WAIT_LOW = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                go_q, go_d;
    logic                result_valid_q, result_valid_d;
    logic [2:0]          drain_cnt_q, drain_cnt_d;
    logic [ADDR_W-1:0]   peak_bin_q, peak_bin_d;
    logic [MAG_W-1:0]    peak_mag_q, peak_mag_d;
    logic [DATA_W-1:0]   peak_re_q, peak_re_d;
    logic [DATA_W-1:0]   peak_im_q, peak_im_d;

    logic                issue;
    logic                flush;
    logic                clear_max;

    // Read-issue tracking: one valid bit and address tag per cycle of RAM latency.
    logic [RD_LAT-1:0]   iss_vld_q, iss_vld_d;
    logic [ADDR_W-1:0]   iss_tag_q [RD_LAT];
    logic [ADDR_W-1:0]   iss_tag_d [RD_LAT];

    logic                      s1_vld_q, s1_vld_d;
    logic [ADDR_W-1:0]         s1_tag_q, s1_tag_d;
    logic [DATA_W-1:0]         s1_re_q, s1_re_d;
    logic [DATA_W-1:0]         s1_im_q, s1_im_d;
    logic [MAG_W-1:0]          s1_re2_q, s1_re2_d;
    logic [MAG_W-1:0]          s1_im2_q, s1_im2_d;

    logic [MAG_W-1:0]          max_mag_q, max_mag_d;
    logic [ADDR_W-1:0]         max_bin_q, max_bin_d;
    logic [DATA_W-1:0]         max_re_q, max_re_d;
    logic [DATA_W-1:0]         max_im_q, max_im_d;

    logic signed [MAG_W-1:0]   s0_re_ext, s0_im_ext;
    logic signed [MAG_W-1:0]   re_sq, im_sq;
    logic [MAG_W-1:0]          mag_sum;

    // Result handshake: result_valid rises with peak_* loaded and holds both stable
    // until result_ack is sampled high; result_ack is ignored while result_valid is low.
    always_comb begin
        state_d        = state_q;
        rd_addr_d      = rd_addr_q;
        go_d           = 1'b0;
        result_valid_d = result_valid_q;
        drain_cnt_d    = drain_cnt_q;
        peak_bin_d     = peak_bin_q;
        peak_mag_d     = peak_mag_q;
        peak_re_d      = peak_re_q;
        peak_im_d      = peak_im_q;
        issue          = 1'b0;
        flush          = 1'b0;
        clear_max      = 1'b0;
        case (state_q)
            S_IDLE: begin
                rd_addr_d = ADDR_LO;
                if (fft_ready) begin
                    state_d   = S_SCAN;
                    clear_max = 1'b1;
                end
            end
            S_SCAN: begin
                if (!fft_ready) begin
                    state_d   = S_IDLE;
                    rd_addr_d = ADDR_LO;
                    flush     = 1'b1;
                end else begin
                    issue = 1'b1;
                    if (rd_addr_q == ADDR_HI) begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = 3'd0;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (!fft_ready) begin
                    state_d   = S_IDLE;
                    rd_addr_d = ADDR_LO;
                    flush     = 1'b1;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    // The last issued bin has left the compare stage; the running max is final.
                    state_d        = S_HOLD;
                    rd_addr_d      = ADDR_LO;
                    result_valid_d = 1'b1;
                    peak_bin_d     = max_bin_q;
                    peak_mag_d     = max_mag_q;
                    peak_re_d      = max_re_q;
                    peak_im_d      = max_im_q;
                end else begin
                    drain_cnt_d = drain_cnt_q + 3'd1;
                end
            end
            S_HOLD: begin
                if (result_ack) begin
                    state_d        = S_RELEASE;
                    result_valid_d = 1'b0;
                end
            end
            S_RELEASE: begin
                go_d    = 1'b1;
                state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!fft_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                rd_addr_d = ADDR_LO;
            end
        endcase
    end

    always_comb begin
        iss_vld_d    = iss_vld_q;
        iss_vld_d[0] = issue;
        iss_tag_d[0] = rd_addr_q;
        for (int i = 1; i < RD_LAT; i++) begin
            iss_vld_d[i] = iss_vld_q[i-1];
            iss_tag_d[i] = iss_tag_q[i-1];
        end
        if (flush) begin
            iss_vld_d = '0;
        end
    end

    assign s0_re_ext = MAG_W'(signed'(ram_q[2*DATA_W-1:DATA_W]));
    assign s0_im_ext = MAG_W'(signed'(ram_q[DATA_W-1:0]));
    assign re_sq     = s0_re_ext * s0_re_ext;
    assign im_sq     = s0_im_ext * s0_im_ext;
    // Each square is at most 2^(2*DATA_W-2), so the sum fits MAG_W bits unsigned.
    assign mag_sum   = s1_re2_q + s1_im2_q;

    always_comb begin
        s1_vld_d = iss_vld_q[RD_LAT-1] && !flush;
        s1_tag_d = iss_tag_q[RD_LAT-1];
        s1_re_d  = ram_q[2*DATA_W-1:DATA_W];
        s1_im_d  = ram_q[DATA_W-1:0];
        s1_re2_d = re_sq;
        s1_im2_d = im_sq;
    end

    // Strict compare so that on equal magnitudes the earliest (lowest) bin is kept.
    always_comb begin
        max_mag_d = max_mag_q;
        max_bin_d = max_bin_q;
        max_re_d  = max_re_q;
        max_im_d  = max_im_q;
        if (clear_max) begin
            max_mag_d = '0;
            max_bin_d = ADDR_LO;
            max_re_d  = '0;
            max_im_d  = '0;
        end else if (s1_vld_q && (mag_sum > max_mag_q)) begin
            max_mag_d = mag_sum;
            max_bin_d = s1_tag_q;
            max_re_d  = s1_re_q;
            max_im_d  = s1_im_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            rd_addr_q      <= ADDR_LO;
            go_q           <= 1'b0;
            result_valid_q <= 1'b0;
            drain_cnt_q    <= 3'd0;
            peak_bin_q     <= '0;
            peak_mag_q     <= '0;
            peak_re_q      <= '0;
            peak_im_q      <= '0;
            iss_vld_q      <= '0;
            s1_vld_q       <= 1'b0;
            max_mag_q      <= '0;
            max_bin_q      <= ADDR_LO;
            max_re_q       <= '0;
            max_im_q       <= '0;
        end else begin
            state_q        <= state_d;
            rd_addr_q      <= rd_addr_d;
            go_q           <= go_d;
            result_valid_q <= result_valid_d;
            drain_cnt_q    <= drain_cnt_d;
            peak_bin_q     <= peak_bin_d;
            peak_mag_q     <= peak_mag_d;
            peak_re_q      <= peak_re_d;
            peak_im_q      <= peak_im_d;
            iss_vld_q      <= iss_vld_d;
            s1_vld_q       <= s1_vld_d;
            max_mag_q      <= max_mag_d;
            max_bin_q      <= max_bin_d;
            max_re_q       <= max_re_d;
            max_im_q       <= max_im_d;
        end
    end

    // Payload registers are qualified by the valids above and need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RD_LAT; i++) begin
            iss_tag_q[i] <= iss_tag_d[i];
        end
        s1_tag_q <= s1_tag_d;
        s1_re_q  <= s1_re_d;
        s1_im_q  <= s1_im_d;
        s1_re2_q <= s1_re2_d;
        s1_im2_q <= s1_im2_d;
    end

    assign rd_addr      = rd_addr_q;
    assign go           = go_q;
    assign busy         = (state_q != S_IDLE);
    assign result_valid = result_valid_q;
    assign peak_bin     = peak_bin_q;
    assign peak_mag     = peak_mag_q;
    assign peak_re      = peak_re_q;
    assign peak_im      = peak_im_q;
    assign dbg_state    = state_q;

endmodule
